// File: rtl/kpn_fifo_channel.sv
// KPN token channel: circular-buffer FIFO with preload and sticky error flags.
// Tokens are 12.4 fixed-point; fmt_err flags writes whose decimal digit exceeds 9.
module kpn_fifo_channel #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 8,
    parameter int               INIT_TOKENS = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    rd,
    output logic [WIDTH-1:0]        data_out,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    fmt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             fmt_q, fmt_d;
    logic             wr_ok, rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        // A full channel still takes a write when a read frees a slot on the same edge.
        wr_ok   = wr & (~full | rd);
        rd_ok   = rd & ~empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q | (wr & ~wr_ok);
        unf_d   = unf_q | (rd & ~rd_ok);
        fmt_d   = fmt_q | (wr_ok & (data_in[3:0] > 4'd9));
        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_q[rptr_q];
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= AW'(INIT_TOKENS % DEPTH);
            rptr_q  <= '0;
            count_q <= CW'(INIT_TOKENS);
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            fmt_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            fmt_q   <= fmt_d;
        end
    end

    // Storage is reset too so preloaded tokens exist straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < INIT_TOKENS) ? INIT_VALUE : '0;
            end
        end else if (wr_ok) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign data_out  = dout_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign fmt_err   = fmt_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Self-checking bench for kpn_fifo_channel against a queue-based token model.
// Directed scenarios plus randomized traffic; two extra instances cover preload.
module tb_kpn_fifo_channel;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        full, empty, overflow, underflow, fmt_err;
    logic [3:0]  count;

    logic        wr2 = 1'b0, rd2 = 1'b0;
    logic [15:0] data_out2;
    logic        full2, empty2, ovf2, unf2, fmt2;
    logic [3:0]  count2;

    logic [15:0] data_out3;
    logic        full3, empty3, ovf3, unf3, fmt3;
    logic [3:0]  count3;

    int tests = 0;
    int fails = 0;

    logic [15:0] mq[$];
    logic [15:0] m_dout;
    logic        m_ovf, m_unf, m_fmt;

    always #5 clk = ~clk;

    kpn_fifo_channel u_dut (
        .clk(clk), .reset(reset), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(data_out), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow), .fmt_err(fmt_err)
    );

    kpn_fifo_channel #(.INIT_TOKENS(2), .INIT_VALUE(16'h0010)) u_init (
        .clk(clk), .reset(reset), .wr(wr2), .data_in(16'h0000), .rd(rd2),
        .data_out(data_out2), .full(full2), .empty(empty2), .count(count2),
        .overflow(ovf2), .underflow(unf2), .fmt_err(fmt2)
    );

    kpn_fifo_channel #(.INIT_TOKENS(8), .INIT_VALUE(16'h0007)) u_full (
        .clk(clk), .reset(reset), .wr(1'b0), .data_in(16'h0000), .rd(1'b0),
        .data_out(data_out3), .full(full3), .empty(empty3), .count(count3),
        .overflow(ovf3), .underflow(unf3), .fmt_err(fmt3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".full"}, 32'(full), 32'(mq.size() == 8));
        check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        check({tag, ".fmt"}, 32'(fmt_err), 32'(m_fmt));
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs are checked before any edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        mq.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_fmt = 1'b0;
        check_all(tag);
        reset = 1'b0;
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r,
                        input string tag);
        bit aw, ar;
        wr = w;
        data_in = d;
        rd = r;
        @(posedge clk);
        aw = w && (mq.size() < 8 || r);
        ar = r && (mq.size() > 0);
        if (w && !aw) m_ovf = 1'b1;
        if (r && !ar) m_unf = 1'b1;
        if (ar) m_dout = mq.pop_front();
        if (aw) begin
            mq.push_back(d);
            if (d[3:0] > 4'd9) m_fmt = 1'b1;
        end
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check_all(tag);
    endtask

    initial begin
        do_reset("rst0");
        check("full3.reset", 32'(full3), 32'd1);
        check("count3.reset", 32'(count3), 32'd8);
        check("count2.reset", 32'(count2), 32'd2);

        rd2 = 1'b1;
        @(posedge clk); #1;
        check("init.rd1", 32'(data_out2), 32'h0010);
        check("init.cnt1", 32'(count2), 32'd1);
        @(posedge clk); #1;
        check("init.rd2", 32'(data_out2), 32'h0010);
        check("init.empty", 32'(empty2), 32'd1);
        check("init.unf0", 32'(unf2), 32'd0);
        @(posedge clk); #1;
        check("init.unf", 32'(unf2), 32'd1);
        rd2 = 1'b0;

        do_reset("rst1");
        step(1, 16'h0125, 0, "b.w0");
        step(1, 16'h0039, 0, "b.w1");
        step(1, 16'h0A07, 0, "b.w2");
        check("b.count3", 32'(count), 32'd3);
        step(0, 16'h0000, 1, "b.r0");
        check("b.d0", 32'(data_out), 32'h0125);
        step(0, 16'h0000, 1, "b.r1");
        step(0, 16'h0000, 1, "b.r2");
        check("b.d2", 32'(data_out), 32'h0A07);
        check("b.empty", 32'(empty), 32'd1);

        do_reset("rst2");
        for (int i = 1; i <= 8; i++) step(1, 16'(i * 16), 0, "o.fill");
        step(1, 16'h0FFF, 0, "o.ovf");
        check("o.ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) step(0, 16'h0000, 1, "o.drain");
        check("o.last", 32'(data_out), 32'h0080);

        do_reset("rst3");
        step(1, 16'h0055, 1, "e.both");
        check("e.unf", 32'(underflow), 32'd1);
        check("e.dout", 32'(data_out), 32'h0000);
        step(0, 16'h0000, 1, "e.rd");
        check("e.val", 32'(data_out), 32'h0055);

        do_reset("rst4");
        for (int i = 0; i < 8; i++) step(1, 16'(16'h0100 + i), 0, "f.fill");
        for (int i = 0; i < 20; i++) step(1, 16'h0099, 1, "f.both");
        check("f.count", 32'(count), 32'd8);
        check("f.ovf", 32'(overflow), 32'd0);

        do_reset("rst5");
        step(1, 16'h003C, 0, "x.fmt");
        check("x.fmt_flag", 32'(fmt_err), 32'd1);
        step(1, 16'h0011, 0, "x.w1");
        step(1, 16'h0022, 0, "x.w2");
        step(0, 16'h0000, 1, "x.r");
        check("x.stored", 32'(data_out), 32'h003C);
        step(1, 16'h0033, 0, "x.w3");
        do_reset("x.async");

        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset("rnd.rst");
            step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
                 1'($urandom_range(0, 1)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kpn_fifo_channel.md
KPN_FIFO_CHANNEL -- requirements
Module: kpn_fifo_channel

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, the token width in 12.4 fixed-point format: bits [15:4] integer, bits [3:0] decimal digit.
REQ-002 The block SHALL provide parameter DEPTH, default 8, the storage depth in tokens; it is a power of two, 2..256.
REQ-003 The block SHALL provide parameter INIT_TOKENS, default 0, the number of tokens preloaded at reset; its range is 0..DEPTH.
REQ-004 The block SHALL provide parameter INIT_VALUE, default 16'h0000, the value of each preloaded token.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port wr, input, 1 bit: producer write request, sampled at the rising edge of clk.
REQ-008 The block SHALL have port data_in, input, WIDTH bits: the token to write.
REQ-009 The block SHALL have port rd, input, 1 bit: consumer read request, sampled at the rising edge of clk.
REQ-010 The block SHALL have port data_out, output, WIDTH bits: the last token read, held between reads.
REQ-011 The block SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-012 The block SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of tokens stored.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set by a write that is refused.
REQ-015 The block SHALL have port underflow, output, 1 bit: sticky flag, set by a read that is refused.
REQ-016 The block SHALL have port fmt_err, output, 1 bit: sticky flag, set when an accepted write has data_in[3:0] > 9.

Function
REQ-017 The block SHALL be a circular buffer with a write pointer and a read pointer, each log2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-018 A write SHALL be accepted when wr=1 and full=0: data_in is stored at the write pointer, and the write pointer increments.
REQ-019 A read SHALL be accepted when rd=1 and empty=0: data_out is loaded from the read pointer on the same edge, so it is valid one cycle after rd, and the read pointer increments.
REQ-020 With rd=1 and wr=1 while full=1, both the read and the write SHALL be accepted, and count SHALL be unchanged.
REQ-021 With rd=1 and wr=1 while empty=1, only the write SHALL be accepted: no bypass, underflow set, data_out held.
REQ-022 With rd=1 and wr=1 in any other state, both SHALL be accepted, and count SHALL be unchanged.
REQ-023 With wr=1 while full=1 and rd=0, the write SHALL be refused, storage left unchanged, and overflow set.
REQ-024 With rd=1 while empty=1, the read SHALL be refused and underflow set.
REQ-025 count SHALL change by +1 on a write only, by -1 on a read only, and by 0 otherwise.
REQ-026 full and empty SHALL be derived from the registered count, valid in the same cycle as count.
REQ-027 Stored tokens SHALL NOT be modified by the channel; fmt_err is a monitor only, and the offending token is still stored.
REQ-028 Once set, overflow, underflow and fmt_err SHALL stay high until reset.

Reset
REQ-029 Asserting reset SHALL, immediately and regardless of clk, set count=INIT_TOKENS and read pointer=0.
REQ-030 Asserting reset SHALL set write pointer=INIT_TOKENS mod DEPTH.
REQ-031 Asserting reset SHALL set data_out=0 and clear overflow, underflow and fmt_err.
REQ-032 Asserting reset SHALL load storage slots 0..INIT_TOKENS-1 with INIT_VALUE.
REQ-033 A reset asserted mid-operation SHALL discard all stored tokens and any read or write on that edge.
REQ-034 After reset deasserts, the first rd/wr SHALL be honoured on the first rising edge of clk with reset low.
REQ-035 With INIT_TOKENS=DEPTH, full SHALL be 1 directly out of reset.

Verification
REQ-036 Defaults: reset, then write 16'h0125, 16'h0039, 16'h0A07, then read 3 times -> data_out = 0125, 0039, 0A07, each one cycle after its rd; count 0->3->0; empty=1 at end.
REQ-037 Fill 8 tokens 16'h0010..16'h0080, then wr 16'h0FFF -> full=1, overflow=1, count=8; 8 reads return 0010..0080, 0FFF never appears.
REQ-038 From empty, rd=1 and wr=1 with 16'h0055 -> underflow=1, count=1, data_out=0; the next rd returns 0055.
REQ-039 From full, rd=1 and wr=1 with 16'h0099 for 20 cycles -> count stays 8 and pointers wrap; output order matches input order.
REQ-040 INIT_TOKENS=2, INIT_VALUE=16'h0010: reset -> count=2; two reads return 0010, 0010; a third read sets underflow.
REQ-041 Write 16'h003C -> fmt_err=1 and the token is stored; then assert reset asynchronously with 3 tokens held -> count=0, flags=0, data_out=0 before the next clk edge.
